// File: rtl/dsram_responder_pkg.sv
// Shared constants and types for the data-SRAM responder.
package dsram_responder_pkg;
  localparam int          STALL_W    = 6;
  localparam int          MEM_HOLD   = 3;
  localparam int          SEL_W      = 8;
  localparam logic [63:0] DSRAM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/dsram_array.sv
// Single-port 64-bit data RAM built from byte lanes; per-lane write enable, registered read.
module dsram_array
  import dsram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [SEL_W-1:0]            be,
  input  logic [DEPTH_LOG2-1:0]       addr,
  input  logic [SEL_W-1:0][7:0]       wdata,
  output logic [SEL_W-1:0][7:0]       rdata
);
  for (genvar i = 0; i < SEL_W; i++) begin : g_lane
    logic [7:0] mem [2**DEPTH_LOG2];
    logic [7:0] q;

    // Read output only moves on a load access, so it holds through WAIT and MEM stalls.
    always_ff @(posedge clk) begin
      if (en && we && be[i]) mem[addr] <= wdata[i];
      if (en && !we)         q <= mem[addr];
    end

    assign rdata[i] = q;
  end
endmodule

// File: rtl/dsram_responder.sv
// Load/store responder between EX and MEM: range check, latency FSM and data array.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1,
  parameter logic [63:0] BASE_ADDR  = DSRAM_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               req_en,
  input  logic               req_we,
  input  logic [SEL_W-1:0]   req_sel,
  input  logic [63:0]        req_addr,
  input  logic [63:0]        req_wdata,
  output logic [63:0]        dsram_rdata,
  output logic               stall_req,
  output logic               addr_err
);
  localparam int CW = $clog2(LATENCY + 1);

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    ld_q, ok_q;
  logic [63:0]             off, arr_rdata;
  logic                    in_range, acc, hold;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    stall_unused;

  assign hold         = stall[MEM_HOLD];
  assign stall_unused = ^{stall[STALL_W-1:MEM_HOLD+1], stall[MEM_HOLD-1:0]};

  // Anything below the base or past the last word is rejected; low 3 bits are lane-select only.
  assign off      = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 3)) == '0);
  assign idx      = off[DEPTH_LOG2+2:3];
  assign acc      = req_en && !hold && (state != S_WAIT) && !rst;

  dsram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (acc && in_range),
    .we    (req_we),
    .be    (req_sel),
    .addr  (idx),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ld_q     <= 1'b0;
      ok_q     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      addr_err <= acc && !in_range;
      if (acc) begin
        ld_q <= !req_we;
        ok_q <= in_range;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    stall_req   = (state == S_WAIT);
    dsram_rdata = (state == S_RESP && ld_q && ok_q) ? arr_rdata : '0;
    if (acc) begin
      if (!req_we && LATENCY > 1) begin
        state_nx = S_WAIT;
        cnt_nx   = CW'(LATENCY - 1);
      end else begin
        state_nx = S_RESP;
      end
    end else begin
      case (state)
        S_WAIT: begin
          cnt_nx = cnt - CW'(1);
          if (cnt == CW'(1)) state_nx = S_RESP;
        end
        S_RESP:  if (!hold) state_nx = S_IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) against a word/byte-level memory model.
module tb_dsram_responder;
  import dsram_responder_pkg::*;

  localparam int          DL2   = 12;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  typedef struct {
    int          dut;
    int          cyc;
    logic [63:0] rd;
    logic        st;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]              rst_v, en_v, we_v, st_v, err_v;
  logic [1:0][STALL_W-1:0] stall_v;
  logic [1:0][7:0]         sel_v;
  logic [1:0][63:0]        addr_v, wd_v, rd_v;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  exp_t sb [$];
  exp_t e;
  logic [63:0] mdl [2][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  dsram_responder #(.DEPTH_LOG2(DL2), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (
    .clk(clk), .rst(rst_v[0]), .stall(stall_v[0]), .req_en(en_v[0]), .req_we(we_v[0]),
    .req_sel(sel_v[0]), .req_addr(addr_v[0]), .req_wdata(wd_v[0]),
    .dsram_rdata(rd_v[0]), .stall_req(st_v[0]), .addr_err(err_v[0]));

  dsram_responder #(.DEPTH_LOG2(DL2), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
    .clk(clk), .rst(rst_v[1]), .stall(stall_v[1]), .req_en(en_v[1]), .req_we(we_v[1]),
    .req_sel(sel_v[1]), .req_addr(addr_v[1]), .req_wdata(wd_v[1]),
    .dsram_rdata(rd_v[1]), .stall_req(st_v[1]), .addr_err(err_v[1]));

  // Every cycle each DUT either matches the queued expectation for that cycle or is fully quiet.
  always @(negedge clk) if (mon_on) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL stale_expect dut=%0d cyc=%0d was never matched (now %0d)", sb[0].dut, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      e = '{k, cyc, 64'd0, 1'b0, 1'b0};
      if (sb.size() > 0 && sb[0].dut == k && sb[0].cyc == cyc) e = sb.pop_front();
      total++;
      if ({rd_v[k], st_v[k], err_v[k]} !== {e.rd, e.st, e.err}) begin
        bad++;
        $display("FAIL out dut=%0d cyc=%0d got rdata=%h stall_req=%b addr_err=%b want rdata=%h stall_req=%b addr_err=%b",
                 k, cyc, rd_v[k], st_v[k], err_v[k], e.rd, e.st, e.err);
      end
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      7:       return BASE - 64'd8;
      8:       return BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 31));
      9:       return 64'hFFFF_FFFF_FFFF_FFF8;
      default: return BASE + 64'(8 * ((r < 4) ? r : DEPTH - 7 + r)) + 64'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic drive(input int k, input logic en, input logic we, input logic [7:0] sel,
                       input logic [63:0] addr, input logic [63:0] wd, input logic hold);
    en_v[k] = en; we_v[k] = we; sel_v[k] = sel; addr_v[k] = addr; wd_v[k] = wd;
    stall_v[k] = 6'($urandom);
    stall_v[k][MEM_HOLD] = hold;
  endtask

  // Called with the DUT able to accept at the next edge; returns with it able to accept again.
  task automatic txn(input int k, input logic we, input logic [7:0] sel, input logic [63:0] addr,
                     input logic [63:0] wd, input int hold, input bit noise);
    int          ea, lat, w;
    logic        ok;
    logic [63:0] rd;
    drive(k, 1'b1, we, sel, addr, wd, 1'b0);
    @(posedge clk); #1;
    ea = cyc;
    ok = (addr >= BASE) && (((addr - BASE) >> 3) < 64'(DEPTH));
    w  = int'((addr - BASE) >> 3);
    rd = '0;
    if (ok && we)
      for (int i = 0; i < 8; i++) if (sel[i]) mdl[k][w][8*i +: 8] = wd[8*i +: 8];
    if (ok && !we) rd = mdl[k][w];
    lat = we ? 1 : lat_of(k);
    for (int c = ea; c < ea + lat - 1; c++) sb.push_back('{k, c, 64'd0, 1'b1, (c == ea) && !ok});
    for (int c = ea + lat - 1; c <= ea + lat - 1 + hold; c++) sb.push_back('{k, c, rd, 1'b0, (c == ea) && !ok});
    for (int c = 1; c < lat; c++) begin
      if (noise) drive(k, 1'b1, 1'b1, 8'hFF, rnd_addr(), {$urandom, $urandom}, 1'b0);
      else       drive(k, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      drive(k, 1'b1, we, sel, addr, wd, 1'b1);
      repeat (hold) begin @(posedge clk); #1; end
    end
    drive(k, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic idle(input int k, input int n, input bit noisy);
    drive(k, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    for (int i = 1; i < n; i++) begin
      if (noisy) drive(k, 1'b1, 1'b1, 8'hFF, rnd_addr(), {$urandom, $urandom}, 1'b1);
      else       drive(k, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
      @(posedge clk); #1;
    end
    drive(k, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic init_words(input int k);
    for (int r = 0; r < 7; r++)
      txn(k, 1'b1, 8'hFF, BASE + 64'(8 * ((r < 4) ? r : DEPTH - 7 + r)), {$urandom, $urandom}, 0, 1'b0);
  endtask

  task automatic rand_txns(input int k, input int n);
    logic [7:0] sel;
    int         hold;
    for (int i = 0; i < n; i++) begin
      sel  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      txn(k, 1'($urandom), sel, rnd_addr(), {$urandom, $urandom}, hold, 1'($urandom));
      if ($urandom_range(0, 4) == 0) idle(k, $urandom_range(1, 3), 1'($urandom));
    end
  endtask

  // Load accepted, then reset lands in the first WAIT cycle: only that one stall cycle is expected.
  task automatic rst_in_wait(input int k, input logic [63:0] addr);
    drive(k, 1'b1, 1'b0, 8'hFF, addr, 64'd0, 1'b0);
    @(posedge clk); #1;
    sb.push_back('{k, cyc, 64'd0, 1'b1, 1'b0});
    rst_v[k] = 1'b1;
    drive(k, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    rst_v[k] = 1'b0;
  endtask

  initial begin
    rst_v = '1; en_v = '0; we_v = '0; sel_v = '0; addr_v = '0; wd_v = '0; stall_v = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_v  = '0;
    mon_on = 1'b1;

    for (int k = 0; k < 2; k++) begin
      init_words(k);
      txn(k, 1'b1, 8'hFF, BASE + 64'h10, 64'h1122334455667788, 0, 1'b0);
      txn(k, 1'b0, 8'hFF, BASE + 64'h10, 64'd0, 0, 1'b1);
      txn(k, 1'b1, 8'h0C, BASE + 64'h10, 64'h00000000AABB0000, 0, 1'b0);
      txn(k, 1'b0, 8'h01, BASE + 64'h13, 64'd0, 0, 1'b1);
      txn(k, 1'b1, 8'h00, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
      txn(k, 1'b0, 8'hFF, BASE + 64'h10, 64'd0, 3, 1'b1);
      txn(k, 1'b1, 8'hFF, BASE, 64'hCAFE_F00D_0123_4567, 0, 1'b0);
      txn(k, 1'b0, 8'hFF, 64'h7FFF_FFF8, 64'd0, 0, 1'b1);
      txn(k, 1'b1, 8'hFF, BASE + 64'(8 * DEPTH), 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b0);
      txn(k, 1'b0, 8'hFF, BASE, 64'd0, 0, 1'b0);
      txn(k, 1'b0, 8'hFF, BASE + 64'(8 * (DEPTH - 1)), 64'd0, 1, 1'b0);
      idle(k, 4, 1'b1);
      rand_txns(k, 150);
      if (k == 1) begin
        idle(k, 2, 1'b0);
        rst_in_wait(k, BASE + 64'h10);
        idle(k, 5, 1'b1);
        txn(k, 1'b0, 8'hFF, BASE + 64'h10, 64'd0, 0, 1'b0);
      end
      idle(k, 4, 1'b0);
    end

    idle(1, 4, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
Data-SRAM responder that services the load/store port driven by the EX stage. It owns the data memory array and returns an aligned 64-bit word to the MEM stage, where MEM does the byte/half/word selection and sign extension. Writes use a per-byte mask, and reads have a parameterised latency. When read data is late, the block raises a stall request to the pipeline controller. It sits between ex_stage (request side) and mem_stage (dsram_rdata consumer).

Parameters:
DEPTH_LOG2, 12, log2 of the number of 64-bit words in the array
LATENCY, 1, cycles from request accept to valid read data; must be >=1
BASE_ADDR, 64'h8000_0000, byte address of word 0

Ports:
clk  input  1  clock
rst  input  1  reset
stall  input  6  pipeline stall vector; bit 3 = MEM stage hold
req_en  input  1  EX issues a memory access this cycle
req_we  input  1  1 = store, 0 = load
req_sel  input  8  byte-lane mask within the 64-bit word; lane i is bits 8i+7:8i
req_addr  input  64  byte address; bits 2:0 are ignored, alignment comes from req_sel
req_wdata  input  64  store data, already lane-aligned by EX
dsram_rdata  output  64  aligned word for the MEM stage; 0 when no load response
stall_req  output  1  asserted while a load's data is not yet valid
addr_err  output  1  one-cycle pulse when an accepted request is out of range

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset: state=IDLE, dsram_rdata=0, stall_req=0, addr_err=0, latency counter=0. Array contents are not reset.
- Accept condition at posedge: req_en & ~stall[3] & (state!=WAIT). No request is accepted while in WAIT. A request held by stall[3] is never accepted twice.
- Index: off = req_addr - BASE_ADDR. in_range = (req_addr >= BASE_ADDR) & (off[63:3] < 2**DEPTH_LOG2). idx = off[DEPTH_LOG2+2:3].
- Out of range: no write occurs, addr_err pulses in the cycle after accept, and the response word is 0 (loads still honour LATENCY).
- Store:
  - At the accept edge, byte lane i of mem[idx] is written when req_sel[i]=1; other lanes are unchanged.
  - req_sel=0 is a no-op.
  - Stores never stall: next state is RESP with dsram_rdata=0.
- Load:
  - The array is read at the accept edge.
  - LATENCY=1: next state RESP, dsram_rdata = mem[idx] in the following cycle (the MEM cycle).
  - LATENCY>1: next state WAIT with counter=LATENCY-1; stall_req=1 while in WAIT and dsram_rdata=0. The counter decrements each cycle; at 1 the next state is RESP with data valid.
- RESP:
  - dsram_rdata is held stable while stall[3]=1 (MEM holds its instruction).
  - When stall[3]=0: accept a new request if req_en (back-to-back, no bubble), otherwise go to IDLE with dsram_rdata=0.
- Store followed by a load to the same word on the next cycle: the load must see the stored bytes. The write commits at edge N and the read happens at edge N+1, so no forwarding path is needed.
- Read data is the full word regardless of req_sel; lane extraction belongs to MEM.
- Reset during WAIT: the pending load is dropped, stall_req falls in the cycle after the reset edge, and there is no response.
- stall_req is a registered-state decode (state==WAIT) with no combinational path from req_*.

Decomposition:
- Shared defines: the stall-vector width and MEM-hold bit index (3), the byte-select width (8), and BASE_ADDR.
- Sub-module dsram_array: single-port synchronous RAM, 2**DEPTH_LOG2 x 64, with an 8-bit byte write-enable and registered read.
- The FSM (IDLE/WAIT/RESP), the latency counter and the range check live in dsram_responder.

Test Plan:
- LATENCY=1: store 0x1122334455667788 to 0x80000010 with sel=0xFF, then load 0x80000010 the next cycle -> dsram_rdata=0x1122334455667788 one cycle after accept; stall_req stays 0.
- Partial store sel=0x0C, wdata=0x00000000AABB0000 over that word, then load -> 0x11223344AABB7788.
- Load accepted with stall[3] held high for 3 cycles -> dsram_rdata is constant for all 3 cycles; the request is accepted exactly once (no duplicate read or counter restart).
- LATENCY=3: load -> stall_req=1 for exactly 2 cycles, then data is valid with stall_req=0; req_en asserted during WAIT is ignored.
- Load from 0x7FFFFFF8, and store to BASE_ADDR + 8*2**DEPTH_LOG2 -> addr_err one-cycle pulse each, rdata=0, and a subsequent read of word 0 is unchanged.
- LATENCY=3: assert rst in the first WAIT cycle -> next cycle state=IDLE, stall_req=0, dsram_rdata=0, and no response appears afterwards.
